regfile_rtype_sequencer: RTL
============================

Name: regfile_rtype_sequencer

Overview:
- Multi-cycle initiator for the 32x32 register bank (2 async read ports RA1/RA2 → DR1/DR2, 1 sync write port WA/WD/WE).
- Accepts one R-type instruction via valid/ready, reads rs/rt, executes the ALU op, and writes rd back.
- Sits between the instruction source (fetch stage or testbench) and the register bank.
- It is the only driver of the bank's address and write ports.

Parameters:
- DATA_W, 32, register and ALU width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  rising-edge clock, shared with the register bank.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present on instr.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  32  op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
- RA1  out  ADDR_W  read address 1 (rs).
- RA2  out  ADDR_W  read address 2 (rt).
- DR1  in  DATA_W  read data 1 from bank (combinational).
- DR2  in  DATA_W  read data 2 from bank (combinational).
- WA  out  ADDR_W  write address (rd).
- WD  out  DATA_W  write data.
- WE  out  1  write enable, one-cycle pulse.
- result  out  DATA_W  last ALU result, held until next completion.
- done  out  1  one-cycle pulse at completion (success or error).
- err  out  1  valid with done: unsupported op/funct; no write performed.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, instr_ready=1, RA1=RA2=WA=0, WD=0, WE=0, result=0, done=0, err=0.
- Reset mid-operation aborts with no write; WE drops immediately.
- Handshake: instruction accepted on a rising edge with instr_valid&&instr_ready. The instruction register latches instr; state goes to READ.
- instr_valid while busy is ignored; the source must hold the instruction until accepted.
- FSM, one cycle per state unless noted:
  - IDLE: instr_ready=1; on accept → READ.
  - READ: RA1=rs, RA2=rt driven from the instruction register; DR1/DR2 latched into op_a/op_b at the end of the cycle. Decode check: op!=0 or funct unsupported → ERR, else → EXEC.
  - EXEC: alu_q <= f(op_a,op_b) → WB.
  - WB: WA=rd, WD=alu_q, WE=(rd!=0); result<=alu_q; done=1 → IDLE.
  - ERR: done=1, err=1, WE=0, result unchanged → IDLE.
- Latency: accept at edge N; WE high during cycle N+3; done pulses in the same cycle. Throughput is one instruction per 4 cycles (per 3 on error).
- Back-to-back instructions: instr_ready=1 in the cycle after WB. The next READ sees the just-written value, because the bank write completes at the WB edge.
- Supported funct values, all modulo 2^32, no overflow trap:
  - 100000 ADD
  - 100010 SUB (a-b)
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 101010 SLT (signed: 1 if a<b else 0)
  - 101011 SLTU (unsigned)
  - 000000 SLL: b<<shamt
  - 000010 SRL: b>>shamt logical
- rd=0: the ALU still executes and result updates, but WE stays 0. Register 0 is never written by this block.
- rs==rt is legal (both ports read the same register). rd==rs is legal; the operands were already latched.
- WE is never high outside WB; WA/WD are 0 outside WB.

Decomposition:
- Shared package: ALU_FUNCT constants (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL), OPCODE_RTYPE=6'b000000, FSM state enum (IDLE, READ, EXEC, WB, ERR), instruction field bit positions.
- One sub-module: rtype_alu. Purely combinational (a, b, shamt, funct → y, unsupported). It is reused later by the single-cycle datapath.

Test Plan:
- Bank preloaded r1=5, r2=7; instr ADD rd=3 rs=1 rt=2 (0x00221820) → WE high 3 cycles after accept, WA=3, WD=12, done=1, err=0, r3=12.
- r1=0x00000003, r2=0xFFFFFFFF → SLT rd=4 gives 0 (3 < -1 is false); SLTU rd=5 gives 1; SUB rd=6 gives 0x00000004.
- ADD rd=0 rs=1 rt=2 → done=1, result=12, WE stays 0 throughout, r0 unchanged.
- funct=6'b001000 (unsupported) or op=6'b100011 → done=1, err=1 two cycles after accept, no WE, result keeps its prior value.
- Back-to-back: ADD r3=r1+r2, then ADD r4=r3+r3 with instr_valid held high → second accepted the cycle after the first WB; r4=24; instr_ready low during READ/EXEC/WB.
- Assert rst_n=0 during EXEC of SUB rd=7 → WE=0 and outputs at reset values immediately, r7 unchanged. After release, instr_ready=1 and a new ADD completes normally.

Source files
------------

// File: rtl/regfile_rtype_sequencer_pkg.sv
// Shared definitions for the R-type sequencer and its ALU: funct codes,
// opcode, FSM state encoding and instruction field positions.
package regfile_rtype_sequencer_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

endpackage

// File: rtl/regfile_rtype_sequencer_alu.sv
// Combinational R-type ALU. Also reused by the single-cycle datapath, so it
// carries no state and flags unsupported funct codes instead of trapping.
module rtype_alu
    import regfile_rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] y,
    output logic              unsupported
);

    // Function select; unknown funct yields zero and raises unsupported.
    always_comb begin
        y           = '0;
        unsupported = 1'b0;
        case (funct)
            FUNCT_ADD:  y = a + b;
            FUNCT_SUB:  y = a - b;
            FUNCT_AND:  y = a & b;
            FUNCT_OR:   y = a | b;
            FUNCT_XOR:  y = a ^ b;
            FUNCT_NOR:  y = ~(a | b);
            FUNCT_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            FUNCT_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
            FUNCT_SLL:  y = b << shamt;
            FUNCT_SRL:  y = b >> shamt;
            default:    unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_rtype_sequencer.sv
// Multi-cycle R-type initiator for a 32x32 register bank: reads rs/rt,
// executes, writes rd. Sole driver of the bank address and write ports.
//
//  state | meaning
//  IDLE  | ready for an instruction; bank ports quiet
//  READ  | RA1/RA2 = rs/rt, latch DR1/DR2, decode check
//  EXEC  | ALU result registered
//  WB    | write rd (unless rd==0), update result, pulse done
//  ERR   | unsupported op/funct: pulse done+err, no write
module regfile_rtype_sequencer
    import regfile_rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] RA1,
    output logic [ADDR_W-1:0] RA2,
    input  logic [DATA_W-1:0] DR1,
    input  logic [DATA_W-1:0] DR2,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] WD,
    output logic              WE,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] IDLE = 3'(S_IDLE);
    localparam logic [2:0] READ = 3'(S_READ);
    localparam logic [2:0] EXEC = 3'(S_EXEC);
    localparam logic [2:0] WB   = 3'(S_WB);
    localparam logic [2:0] ERR  = 3'(S_ERR);

    logic [2:0]        state_q,  state_d;
    logic [31:0]       instr_q,  instr_d;
    logic [DATA_W-1:0] op_a_q,   op_a_d;
    logic [DATA_W-1:0] op_b_q,   op_b_d;
    logic [DATA_W-1:0] alu_q,    alu_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] alu_y;
    logic              alu_unsup;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr = ADDR_W'(instr_q[RD_HI:RD_LO]);

    rtype_alu #(.DATA_W(DATA_W)) u_alu (
        .a           (op_a_q),
        .b           (op_b_q),
        .shamt       (instr_q[SHAMT_HI:SHAMT_LO]),
        .funct       (instr_q[FUNCT_HI:FUNCT_LO]),
        .y           (alu_y),
        .unsupported (alu_unsup)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        alu_d    = alu_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = READ;
                end
            end
            READ: begin
                op_a_d  = DR1;
                op_b_d  = DR2;
                state_d = ((instr_q[OP_HI:OP_LO] != OPCODE_RTYPE) || alu_unsup) ? ERR : EXEC;
            end
            EXEC: begin
                alu_d   = alu_y;
                state_d = WB;
            end
            WB: begin
                result_d = alu_q;
                state_d  = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset also aborts any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            alu_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            alu_q    <= alu_d;
            result_q <= result_d;
        end
    end

    // Bank and handshake outputs decoded from state; quiet (zero) outside their state.
    always_comb begin
        instr_ready = (state_q == IDLE);
        RA1         = '0;
        RA2         = '0;
        WA          = '0;
        WD          = '0;
        WE          = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            READ: begin
                RA1 = ADDR_W'(instr_q[RS_HI:RS_LO]);
                RA2 = ADDR_W'(instr_q[RT_HI:RT_LO]);
            end
            WB: begin
                WA   = rd_addr;
                WD   = alu_q;
                WE   = (rd_addr != '0);
                done = 1'b1;
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign result = result_q;

endmodule
